// File: rtl/writeback_arb.sv
// rtl/writeback_arb.sv - merges NUM_SRC result producers onto NUM_WP register-file write ports
module writeback_arb #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 3,
    parameter int NUM_WP  = 1,
    parameter int RR_EN   = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    input  logic [NUM_SRC*5-1:0]      src_rd_i,
    input  logic [NUM_SRC*XLEN-1:0]   src_data_i,
    output logic [NUM_SRC-1:0]        src_ready_o,
    output logic [NUM_WP-1:0]         rf_we_o,
    output logic [NUM_WP*5-1:0]       rf_waddr_o,
    output logic [NUM_WP*XLEN-1:0]    rf_wdata_o,
    output logic [31:0]               wb_count_o
);
    localparam int PW = $clog2(NUM_SRC);

    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            rr_nxt;
    logic [NUM_SRC-1:0]       grant;
    logic [NUM_WP-1:0]        we_nxt;
    logic [NUM_WP*5-1:0]      waddr_nxt;
    logic [NUM_WP*XLEN-1:0]   wdata_nxt;
    int                       pos [NUM_SRC];
    int                       slots;
    int                       last_late;
    logic                     conflict;

    // pos[k] is the priority rank of source k; grants are handed out in rank order
    always_comb begin
        grant     = '0;
        we_nxt    = '0;
        waddr_nxt = '0;
        wdata_nxt = '0;
        rr_nxt    = rr_ptr;
        slots     = 0;
        last_late = 0;
        conflict  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (k == 0)
                pos[k] = 0;
            else if (RR_EN != 0)
                pos[k] = ((k - int'(rr_ptr) + NUM_SRC - 1) % (NUM_SRC - 1)) + 1;
            else
                pos[k] = k;
        end
        if (!rst_i && !stall_i) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (pos[k] == j) begin
                        conflict = 1'b0;
                        for (int m = 0; m < NUM_SRC; m++) begin
                            if (grant[m] && src_rd_i[5*k +: 5] != 5'd0 &&
                                src_rd_i[5*m +: 5] == src_rd_i[5*k +: 5])
                                conflict = 1'b1;
                        end
                        if (src_valid_i[k] && slots < NUM_WP && !conflict) begin
                            grant[k] = 1'b1;
                            if (k != 0)
                                last_late = k;
                            // rd==0 and flushed results still occupy their slot, they just never write
                            for (int p = 0; p < NUM_WP; p++) begin
                                if (p == slots && src_rd_i[5*k +: 5] != 5'd0 && !(k == 0 && flush_i)) begin
                                    we_nxt[p]                  = 1'b1;
                                    waddr_nxt[5*p +: 5]        = src_rd_i[5*k +: 5];
                                    wdata_nxt[XLEN*p +: XLEN]  = src_data_i[XLEN*k +: XLEN];
                                end
                            end
                            slots = slots + 1;
                        end
                    end
                end
            end
            if (last_late != 0)
                rr_nxt = (last_late == NUM_SRC - 1) ? PW'(1) : PW'(last_late + 1);
        end
    end

    assign src_ready_o = grant;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o    <= '0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            wb_count_o <= '0;
            rr_ptr     <= PW'(1);
        end else begin
            rf_we_o    <= we_nxt;
            rf_waddr_o <= waddr_nxt;
            rf_wdata_o <= wdata_nxt;
            wb_count_o <= wb_count_o + 32'($countones(rf_we_o));
            rr_ptr     <= rr_nxt;
        end
    end
endmodule

// File: tb/tb_writeback_arb.sv
// tb/tb_writeback_arb.sv - directed vector bench for writeback_arb (1-port and 2-port builds)
module tb_writeback_arb;
    typedef struct {
        logic        stall;
        logic        flush;
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] data;
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [2:0]  v1, v2;
    logic [14:0] rd1, rd2;
    logic [95:0] data1, data2;
    logic [2:0]  ready1, ready2;
    logic [0:0]  we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1, cnt1, cnt2;
    logic [1:0]  we2;
    logic [9:0]  waddr2;
    logic [63:0] wdata2;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t tbl [15];

    writeback_arb #(.XLEN(32), .NUM_SRC(3), .NUM_WP(1), .RR_EN(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .src_valid_i(v1), .src_rd_i(rd1), .src_data_i(data1), .src_ready_o(ready1),
        .rf_we_o(we1), .rf_waddr_o(waddr1), .rf_wdata_o(wdata1), .wb_count_o(cnt1)
    );

    writeback_arb #(.XLEN(32), .NUM_SRC(3), .NUM_WP(2), .RR_EN(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .src_valid_i(v2), .src_rd_i(rd2), .src_data_i(data2), .src_ready_o(ready2),
        .rf_we_o(we2), .rf_waddr_o(waddr2), .rf_wdata_o(wdata2), .wb_count_o(cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic [2:0] v,
                                input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [2:0] rdy, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd);
        vec_t t;
        t.stall = s; t.flush = f; t.valid = v;
        t.rd = {r2, r1, r0}; t.data = {d2, d1, d0};
        t.ready = rdy; t.we = we; t.waddr = wa; t.wdata = wd;
        return t;
    endfunction

    task automatic step2(input string name, input logic [2:0] v, input logic [14:0] r,
                         input logic [95:0] d, input logic [2:0] exp_rdy, input logic [1:0] exp_we,
                         input logic [9:0] exp_wa, input logic [63:0] exp_wd);
        v2 = v; rd2 = r; data2 = d;
        #1;
        chk({name, "_ready"}, 64'(ready2), 64'(exp_rdy));
        @(posedge clk); #1;
        chk({name, "_we"}, 64'(we2), 64'(exp_we));
        chk({name, "_waddr"}, 64'(waddr2), 64'(exp_wa));
        chk({name, "_wdata"}, wdata2, exp_wd);
    endtask

    initial begin
        int acc;
        //               st fl valid   r0  r1  r2  d0     d1     d2     ready   we wa  wd
        tbl[0]  = mk(0, 0, 3'b011,  5,  6,  0, 'h11,  'h22,  0,     3'b001, 1, 5,  'h11);
        tbl[1]  = mk(0, 0, 3'b010,  0,  6,  0, 0,     'h22,  0,     3'b010, 1, 6,  'h22);
        tbl[2]  = mk(0, 0, 3'b110,  0, 10, 11, 0,     'hA1,  'hA2,  3'b100, 1, 11, 'hA2);
        tbl[3]  = mk(0, 0, 3'b110,  0, 10, 11, 0,     'hA1,  'hA2,  3'b010, 1, 10, 'hA1);
        tbl[4]  = mk(0, 0, 3'b110,  0, 10, 11, 0,     'hA1,  'hA2,  3'b100, 1, 11, 'hA2);
        tbl[5]  = mk(0, 1, 3'b011,  9, 12,  0, 'h99,  'hC1,  0,     3'b001, 0, 0,  0);
        tbl[6]  = mk(0, 0, 3'b001,  0,  0,  0, 'h55,  0,     0,     3'b001, 0, 0,  0);
        tbl[7]  = mk(0, 0, 3'b010,  0,  0,  0, 0,     'h66,  0,     3'b010, 0, 0,  0);
        tbl[8]  = mk(1, 0, 3'b111,  1,  2,  3, 1,     2,     3,     3'b000, 0, 0,  0);
        tbl[9]  = mk(1, 0, 3'b111,  1,  2,  3, 1,     2,     3,     3'b000, 0, 0,  0);
        tbl[10] = mk(1, 0, 3'b111,  1,  2,  3, 1,     2,     3,     3'b000, 0, 0,  0);
        tbl[11] = mk(0, 0, 3'b111,  1,  2,  3, 1,     2,     3,     3'b001, 1, 1,  1);
        tbl[12] = mk(0, 0, 3'b110,  0,  2,  3, 0,     2,     3,     3'b100, 1, 3,  3);
        tbl[13] = mk(0, 0, 3'b000,  0,  0,  0, 0,     0,     0,     3'b000, 0, 0,  0);
        tbl[14] = mk(0, 0, 3'b010,  0, 14,  0, 0,     'hE1,  0,     3'b010, 1, 14, 'hE1);

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        v1 = 3'b111; rd1 = {5'd3, 5'd2, 5'd1}; data1 = '0;
        v2 = '0; rd2 = '0; data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready1), 64'(3'b000));
        chk("rst_we", 64'(we1), 64'(0));
        chk("rst_waddr", 64'(waddr1), 64'(0));
        chk("rst_wdata", 64'(wdata1), 64'(0));
        chk("rst_count", 64'(cnt1), 64'(0));
        chk("rst_we2", 64'(we2), 64'(0));
        rst = 1'b0;

        acc = 0;
        for (int i = 0; i < 15; i++) begin
            stall = tbl[i].stall; flush = tbl[i].flush;
            v1 = tbl[i].valid; rd1 = tbl[i].rd; data1 = tbl[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(ready1), 64'(tbl[i].ready));
            @(posedge clk); #1;
            chk($sformatf("v%0d_we", i), 64'(we1), 64'(tbl[i].we));
            chk($sformatf("v%0d_waddr", i), 64'(waddr1), 64'(tbl[i].waddr));
            chk($sformatf("v%0d_wdata", i), 64'(wdata1), 64'(tbl[i].wdata));
            chk($sformatf("v%0d_count", i), 64'(cnt1), 64'(acc));
            acc = acc + int'(tbl[i].we);
        end
        stall = 1'b0; flush = 1'b0;

        // counter wrap: the write from the last vector is still on the port
        v1 = 3'b001; rd1 = {5'd0, 5'd0, 5'd15}; data1 = {64'd0, 32'hF0};
        force dut1.wb_count_o = 32'hFFFF_FFFF;
        #1;
        release dut1.wb_count_o;
        chk("wrap_preload", 64'(cnt1), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("wrap_count", 64'(cnt1), 64'(0));
        chk("wrap_we", 64'(we1), 64'(1));
        chk("wrap_waddr", 64'(waddr1), 64'(15));

        // reset with a write in flight; rr_ptr was 2 beforehand
        rst = 1'b1;
        v1 = 3'b110; rd1 = {5'd18, 5'd17, 5'd0}; data1 = {32'h18, 32'h17, 32'd0};
        #1;
        chk("rstf_ready", 64'(ready1), 64'(0));
        @(posedge clk); #1;
        chk("rstf_we", 64'(we1), 64'(0));
        chk("rstf_waddr", 64'(waddr1), 64'(0));
        chk("rstf_count", 64'(cnt1), 64'(0));
        rst = 1'b0;
        #1;
        chk("rstf_rr_ready", 64'(ready1), 64'(3'b010));
        @(posedge clk); #1;
        chk("rstf_rr_waddr", 64'(waddr1), 64'(17));
        chk("rstf_rr_wdata", 64'(wdata1), 64'(32'h17));
        v1 = '0;

        // two write ports
        step2("p2_s1", 3'b101, {5'd7, 5'd0, 5'd7}, {32'h72, 32'h0, 32'h70},
              3'b001, 2'b01, 10'd7, 64'h70);
        step2("p2_s2", 3'b100, {5'd7, 5'd0, 5'd0}, {32'h72, 32'h0, 32'h0},
              3'b100, 2'b01, 10'd7, 64'h72);
        step2("p2_s3", 3'b111, {5'd6, 5'd5, 5'd4}, {32'h62, 32'h51, 32'h40},
              3'b011, 2'b11, {5'd5, 5'd4}, {32'h51, 32'h40});
        step2("p2_s4", 3'b110, {5'd6, 5'd5, 5'd0}, {32'h62, 32'h51, 32'h0},
              3'b110, 2'b11, {5'd5, 5'd6}, {32'h51, 32'h62});
        step2("p2_s5", 3'b110, {5'd8, 5'd8, 5'd0}, {32'h82, 32'h81, 32'h0},
              3'b100, 2'b01, 10'd8, 64'h82);
        chk("p2_count_a", 64'(cnt2), 64'(6));
        step2("p2_s6", 3'b010, {5'd0, 5'd8, 5'd0}, {32'h0, 32'h81, 32'h0},
              3'b010, 2'b01, 10'd8, 64'h81);
        chk("p2_count_b", 64'(cnt2), 64'(7));
        v2 = '0;
        @(posedge clk); #1;
        chk("p2_count_c", 64'(cnt2), 64'(8));
        chk("p2_idle_we", 64'(we2), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/writeback_arb.md
Name: writeback_arb

Overview:
- Parametrised successor to the single-source writeback stage.
- Merges NUM_SRC result producers onto NUM_WP register-file write ports:
  - source 0: in-order pipeline result.
  - sources 1..NUM_SRC-1: long-latency units (mul/div, miss-return loads).
- Valid/ready handshake per source, round-robin fairness among late sources, registered write outputs, stall/flush gating and a retired-write counter.
- Sits between the memory stage / late units and the register file.

Parameters:
- XLEN, 32, data width.
- NUM_SRC, 3, number of result sources (2..8).
- NUM_WP, 1, register-file write ports (1..2, NUM_WP < NUM_SRC).
- RR_EN, 1, 1 = round-robin among sources 1..NUM_SRC-1; 0 = fixed priority, lower index wins.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- stall_i  in  1  pipeline freeze: no grants this cycle.
- flush_i  in  1  kill source-0 result this cycle.
- src_valid_i  in  NUM_SRC  result valid per source.
- src_rd_i  in  NUM_SRC*5  destination register per source; source k at bits [5k+4:5k].
- src_data_i  in  NUM_SRC*XLEN  result data per source; source k at [XLEN*k +: XLEN].
- src_ready_o  out  NUM_SRC  result accepted this cycle (combinational).
- rf_we_o  out  NUM_WP  register-file write enable per port.
- rf_waddr_o  out  NUM_WP*5  write address per port.
- rf_wdata_o  out  NUM_WP*XLEN  write data per port.
- wb_count_o  out  32  total register-file writes performed.

Behaviour:
- Handshake and latency:
  - Source k is consumed when src_valid_i[k] && src_ready_o[k].
  - The consumed result appears on a write port registered, exactly 1 cycle later.
  - rf_we_o is high for exactly one cycle per accepted, non-suppressed result.
- Grant rules, evaluated combinationally each cycle:
  - stall_i=1: src_ready_o = 0 for all sources; the output register loads rf_we_o=0 next cycle.
  - Source 0 has absolute priority. If valid, it takes port 0.
  - Remaining free ports (NUM_WP, minus 1 if source 0 is granted) go to sources 1..NUM_SRC-1:
    - RR_EN=1: round-robin starting at rr_ptr.
    - RR_EN=0: ascending index.
- Same-rd conflict:
  - Two candidates with equal non-zero rd in one cycle: only the higher-priority one is granted. The other keeps ready=0 and retries next cycle.
  - Source 0 always beats late sources.
- rd==0: granted normally (ready=1) but no write is generated. Its port slot is still consumed.
- flush_i=1: src_ready_o[0]=1 whenever src_valid_i[0]=1 (the result is dropped), no write is generated, and the port slot is consumed. Late sources are unaffected.
- Port assignment: granted results fill ports in ascending port index, in grant order. Unused ports have rf_we_o=0; their waddr/wdata are don't-care but held at 0.
- rr_ptr:
  - Range 1..NUM_SRC-1; reset value 1.
  - After any cycle with a late-source grant, rr_ptr = (last granted late index)+1, wrapping NUM_SRC-1 -> 1.
  - Unchanged otherwise, including during stall.
- wb_count_o: increments each cycle by popcount(rf_we_o). Wraps modulo 2^32 (0xFFFFFFFF + 1 -> 0).
- Reset (rst_i=1 at a clock edge) clears rf_we_o, rf_waddr_o, rf_wdata_o, wb_count_o and sets rr_ptr=1. src_ready_o is forced to 0 while rst_i=1.
  - Reset asserted mid-operation discards any registered, not-yet-written result. No write occurs in the cycle after reset.
- src_ready_o must not depend on src_valid_i of the same source beyond the grant logic. The ready computation has no combinational path to rf_*_o.

Test Plan:
- NUM_SRC=3, NUM_WP=1; src0 valid rd=5 data=0x11 and src1 valid rd=6 data=0x22 in the same cycle -> ready=3'b001; next cycle rf_we=1, waddr=5, wdata=0x11. src1 is granted the following cycle and writes rd=6, data=0x22 one cycle later.
- RR_EN=1, src1 and src2 continuously valid, src0 idle -> grants alternate 1,2,1,2. wb_count_o increments by 1 per cycle after the first write.
- NUM_WP=2; src0 rd=7 and src2 rd=7 valid together -> only src0 granted, port0 writes rd=7. src2 is granted next cycle.
- src0 valid rd=9 with flush_i=1 -> ready[0]=1, rf_we=0 next cycle, wb_count_o unchanged. The same stimulus with rd=0 and flush_i=0 also gives no write.
- stall_i=1 for 3 cycles with all sources valid -> ready=0 and rf_we=0 throughout. After the stall releases, src0 writes on the first cycle.
- Preload wb_count_o to 0xFFFFFFFF via 2^32-1 writes (or a force), perform one write -> wb_count_o=0. Assert rst_i with a grant in flight -> no write in the next cycle and rr_ptr=1.
